reload_down_counter: RTL and testbench
======================================

// Module: reload_down_counter
// PURPOSE
// - Parametrised reloadable down counter for UART baud/bit timing and generic timeouts.
// - Loaded with a start value, counts down on enable and flags terminal count (tc).
// - Modes: one-shot (stop at 0) or periodic (auto-reload, fixed-period tick).
// - Drives baud tick generation and bit/stop-bit counting in the TX and RX paths.
// PARAMETERS
// - WIDTH        10   counter and load-value width in bits (>= 2)
// PORTS
// - clk          in   1      clock, rising edge
// - rst          in   1      reset, asynchronous, active-low
// - en           in   1      count enable; one decrement per enabled cycle in RUN
// - load         in   1      load load_val, latch mode, start counting
// - load_val     in   WIDTH  start/reload value N
// - periodic     in   1      mode, sampled only when load=1: 1 = periodic, 0 = one-shot
// - stop         in   1      abort a running count; cnt holds its value
// - cnt          out  WIDTH  current count
// - tc           out  1      terminal-count pulse, 1 cycle, registered
// - busy         out  1      1 while in RUN
// BEHAVIOUR
// - Reset (rst=0, async): cnt=0, reload_reg=0, mode_reg=0, tc=0, busy=0, state=IDLE.
// - FSM states: IDLE, RUN. busy = (state==RUN). All outputs are registered.
// - Priority, highest first: load > stop > count.
// - load=1, any state: cnt<=load_val, reload_reg<=load_val, mode_reg<=periodic, tc<=0.
//   - load_val != 0: go to RUN.
//   - load_val == 0: go to IDLE, no tc.
// - stop=1 (no load) in RUN: go to IDLE, cnt holds, tc<=0. stop in IDLE has no effect.
// - RUN, en=1, cnt>1: cnt<=cnt-1, tc<=0.
// - RUN, en=1, cnt==1: tc<=1. tc is high in the same cycle cnt shows its new value.
//   - mode_reg=0: cnt<=0, go to IDLE.
//   - mode_reg=1: cnt<=reload_reg, stay in RUN.
//   - Periodic tc period = exactly N enabled cycles. N=1 gives tc on every enabled cycle.
// - RUN, en=0: cnt holds, tc<=0. A pending terminal count is delayed, not lost.
// - IDLE: cnt holds, never decrements, never wraps below 0. en is ignored.
// - Simultaneous load and cnt==1 with en=1: load wins, tc stays 0.
// - Simultaneous load and stop: load wins.
// - Latency: load to first decrement is 1 cycle. Terminal en cycle to tc high is 1 cycle.
// - Arithmetic is unsigned, WIDTH bits. Max count is 2^WIDTH-1. No underflow path exists.
// - Reset asserted mid-count: immediate return to reset values; no tc is emitted.
// CONFIGURATION
// - Macro DCNT_TC_COUNT_EN.
//   - Defined: adds output tc_count [7:0].
//     - Increments on every cycle with tc=1 and saturates at 255.
//     - Cleared to 0 by reset and by load.
//   - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
// - Reset mid-RUN (cnt=5): cnt=0, busy=0, tc=0 asynchronously; no tc after release.
// - One-shot: load_val=3, periodic=0, en=1 -> cnt 3,2,1,0; tc=1 only with cnt=0.
//   Then busy=0 and cnt stays 0 for 10 more cycles.
// - Periodic: load_val=4, periodic=1, en=1 for 20 cycles -> tc on cycles 4,8,12,16,20.
//   cnt reloads to 4 in each tc cycle. With en toggling 1/0, tc spacing = 4 enabled cycles.
// - Boundaries:
//   - load_val=0 -> busy stays 0, no tc.
//   - load_val=2^WIDTH-1 one-shot -> tc after exactly 1023 enabled cycles (WIDTH=10).
//   - load_val=1 periodic -> tc on every enabled cycle.
// - Collisions:
//   - load (load_val=7) in the cycle cnt==1 -> tc=0, cnt=7.
//   - stop at cnt=5 -> cnt holds 5, busy=0.
//   - load together with stop -> RUN with cnt=load_val.
// - DCNT_TC_COUNT_EN: periodic load_val=1 for 300 cycles -> tc_count=255 (saturated).
//   A following load clears tc_count to 0.

Source files
------------

// File: rtl/reload_down_counter.sv
// Reloadable down counter (one-shot / periodic) flagging terminal count; optional DCNT_TC_COUNT_EN adds tc_count.
// Latency: load to first decrement 1 cycle; terminal enabled cycle to tc 1 cycle; all outputs registered.
// No backpressure: en gates decrements; a pending terminal count waits for the next enabled cycle.
module reload_down_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    input  logic             stop,
`ifdef DCNT_TC_COUNT_EN
    output logic [7:0]       tc_count,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             mode_reg;

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
            tc         <= 1'b0;
        end else if (load) begin
            cnt        <= load_val;
            reload_reg <= load_val;
            mode_reg   <= periodic;
            tc         <= 1'b0;
            state      <= (load_val != '0) ? RUN : IDLE;
        end else if (state == RUN && stop) begin
            state <= IDLE;
            tc    <= 1'b0;
        end else if (state == RUN && en) begin
            if (cnt > WIDTH'(1)) begin
                cnt <= cnt - WIDTH'(1);
                tc  <= 1'b0;
            end else begin
                // Terminal step: reload_reg is never 0 while in RUN, so periodic stays live.
                tc <= 1'b1;
                if (mode_reg) begin
                    cnt <= reload_reg;
                end else begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

`ifdef DCNT_TC_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_count <= '0;
        end else if (load) begin
            tc_count <= '0;
        end else if (tc && tc_count != 8'hFF) begin
            tc_count <= tc_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reload_down_counter.sv
// Scoreboard bench for reload_down_counter: stimulus queues expected cnt/tc/busy, a monitor compares after each edge.
module tb_reload_down_counter;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         periodic = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
`ifdef DCNT_TC_COUNT_EN
    logic [7:0]   tc_count;
`endif

    reload_down_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .periodic (periodic),
        .stop     (stop),
`ifdef DCNT_TC_COUNT_EN
        .tc_count (tc_count),
`endif
        .cnt      (cnt),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         busy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    // Monitor: the DUT presents a fresh registered output after every rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (cnt !== e.cnt || tc !== e.tc || busy !== e.busy) begin
                failures++;
                $display("FAIL %s: got cnt=%0d tc=%b busy=%b, expected cnt=%0d tc=%b busy=%b",
                         nm, cnt, tc, busy, e.cnt, e.tc, e.busy);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic e, input logic ld, input int lv, input logic per,
                        input logic stp, input int ec, input logic et, input logic eb,
                        input string nm);
        exp_t x;
        @(negedge clk);
        en       = e;
        load     = ld;
        load_val = W'(lv);
        periodic = per;
        stop     = stp;
        x.cnt    = W'(ec);
        x.tc     = et;
        x.busy   = eb;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int e_cnt;
        #1;
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tc", int'(tc), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset mid-RUN at cnt=5
        step(0, 1, 5, 0, 0, 5, 0, 1, "mid_load5");
        step(0, 0, 0, 0, 0, 5, 0, 1, "mid_hold5");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rst_cnt", int'(cnt), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_tc", int'(tc), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, "post_rst_idle");

        // One-shot 3
        step(1, 1, 3, 0, 0, 3, 0, 1, "os_load3");
        step(1, 0, 0, 0, 0, 2, 0, 1, "os_cnt2");
        step(1, 0, 0, 0, 0, 1, 0, 1, "os_cnt1");
        step(1, 0, 0, 0, 0, 0, 1, 0, "os_tc");
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0, 0, "os_idle_hold");

        // Periodic 4, 20 enabled cycles: tc on 4,8,12,16,20
        step(1, 1, 4, 1, 0, 4, 0, 1, "per_load4");
        for (int i = 1; i <= 20; i++)
            step(1, 0, 0, 0, 0, (i % 4 == 0) ? 4 : 4 - (i % 4), (i % 4 == 0), 1, "per4_run");
        // en toggling: tc spacing counts enabled cycles only
        e_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                e_cnt++;
                step(1, 0, 0, 0, 0, (e_cnt % 4 == 0) ? 4 : 4 - (e_cnt % 4), (e_cnt % 4 == 0), 1,
                     "per4_toggle_en");
            end else begin
                step(0, 0, 0, 0, 0, (e_cnt % 4 == 0) ? 4 : 4 - (e_cnt % 4), 0, 1,
                     "per4_toggle_hold");
            end
        end
        step(1, 0, 0, 0, 1, 4, 0, 0, "per4_stop");

        // load_val=0 never runs
        step(1, 1, 0, 1, 0, 0, 0, 0, "zero_load");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, "zero_idle");

        // Max value one-shot: tc after exactly 1023 enabled cycles
        step(1, 1, 1023, 0, 0, 1023, 0, 1, "max_load");
        for (int i = 1; i <= 1023; i++)
            step(1, 0, 0, 0, 0, 1023 - i, (i == 1023), (i < 1023), "max_run");
        step(1, 0, 0, 0, 0, 0, 0, 0, "max_after");

        // Periodic N=1: tc every enabled cycle
        step(1, 1, 1, 1, 0, 1, 0, 1, "n1_load");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 1, 1, "n1_tc");
        step(0, 0, 0, 0, 0, 1, 0, 1, "n1_en0");

        // load collides with terminal cycle
        step(1, 1, 2, 0, 0, 2, 0, 1, "col_load2");
        step(1, 0, 0, 0, 0, 1, 0, 1, "col_cnt1");
        step(1, 1, 7, 0, 0, 7, 0, 1, "col_load7_wins");
        step(1, 0, 0, 0, 0, 6, 0, 1, "col_cnt6");

        // stop at cnt=5
        step(1, 0, 0, 0, 0, 5, 0, 1, "stop_cnt5");
        step(1, 0, 0, 0, 1, 5, 0, 0, "stop_hold5");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5, 0, 0, "stop_idle5");
        step(1, 0, 0, 0, 1, 5, 0, 0, "stop_in_idle");

        // load with stop: load wins
        step(1, 1, 9, 0, 1, 9, 0, 1, "ldstop_load9");
        step(1, 0, 0, 0, 0, 8, 0, 1, "ldstop_cnt8");

        // Pending terminal count delayed by en=0, not lost
        step(1, 1, 2, 0, 0, 2, 0, 1, "pend_load2");
        step(1, 0, 0, 0, 0, 1, 0, 1, "pend_cnt1");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 1, "pend_hold");
        step(1, 0, 0, 0, 0, 0, 1, 0, "pend_tc");
        step(0, 0, 0, 0, 0, 0, 0, 0, "pend_after");

`ifdef DCNT_TC_COUNT_EN
        step(1, 1, 1, 1, 0, 1, 0, 1, "tcc_load1");
        for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0, 1, 1, 1, "tcc_run");
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("tc_count_saturated", int'(tc_count), 255);
        step(0, 1, 3, 0, 0, 3, 0, 1, "tcc_reload");
        @(posedge clk);
        #2;
        chk("tc_count_cleared", int'(tc_count), 0);
`endif

        @(negedge clk);
        en   = 1'b0;
        load = 1'b0;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
